cmsdk_apb_watchdog_kicker: RTL and testbench
============================================

CMSDK_APB_WATCHDOG_KICKER -- requirements
Module: cmsdk_apb_watchdog_kicker

Interface
REQ-001 The block SHALL be an APB initiator that configures and periodically services the CMSDK APB watchdog (zero-wait-state responder, no PREADY/PSLVERR).
REQ-002 Parameter LOAD_VALUE, 32'h0000_FFFF, value written to watchdog LOAD during init.
REQ-003 Parameter CTRL_VALUE, 2'b11, value written to watchdog CONTROL[1:0]: bit0 INTEN, bit1 RESEN.
REQ-004 Parameter KICK_PERIOD, 32'd1000, PCLK cycles between autonomous kicks; 0 disables autonomous kicks.
REQ-005 PCLK  input  1  APB clock, sole clock.
REQ-006 PRESETn  input  1  reset, asynchronous, active-low.
REQ-007 PSEL  output  1  APB select.
REQ-008 PENABLE  output  1  APB enable.
REQ-009 PADDR  output  [11:2]  APB word address.
REQ-010 PWRITE  output  1  APB write.
REQ-011 PWDATA  output  32  APB write data.
REQ-012 PRDATA  input  32  APB read data.
REQ-013 enable  input  1  level; rising edge starts init, low stops kicking.
REQ-014 kick_req  input  1  single-cycle software kick request.
REQ-015 busy  output  1  high while any APB sequence is in progress.
REQ-016 init_done  output  1  level; high after init verified.
REQ-017 kick_done  output  1  one-cycle pulse on a verified kick.
REQ-018 lock_err  output  1  one-cycle pulse when lock readback fails.

Function
REQ-019 Every transfer SHALL be two cycles: SETUP (PSEL=1, PENABLE=0), then ACCESS (PSEL=1, PENABLE=1); PADDR/PWRITE/PWDATA stable across both.
REQ-020 Back-to-back transfers SHALL issue with no idle cycle (next SETUP immediately after ACCESS); PSEL=0 and PENABLE=0 between sequences.
REQ-021 Read data SHALL be sampled at the end of the ACCESS cycle.
REQ-022 Word addresses: LOAD 10'h000, CONTROL 10'h002, INTCLR 10'h003, LOCK 10'h300; unlock key 32'h1ACCE551; lock value 32'h0.
REQ-023 INIT sequence, 5 transfers: write LOCK=key; write LOAD=LOAD_VALUE; write CONTROL={30'b0,CTRL_VALUE}; write LOCK=0; read LOCK.
REQ-024 KICK sequence, 4 transfers: write LOCK=key; write INTCLR=32'h1; write LOCK=0; read LOCK.
REQ-025 FSM states: IDLE, SETUP, ACCESS, WAIT; a 4-bit op index selects the current transfer from a fixed table (ops 0-4 INIT, 5-8 KICK).
REQ-026 IDLE->SETUP(op0) SHALL occur the cycle after enable is sampled rising; busy is high from that SETUP until the cycle after the final ACCESS.
REQ-027 When the final read has PRDATA[0]=1: INIT sets init_done and enters WAIT; KICK pulses kick_done and returns to WAIT; pulse/set in the cycle after the final ACCESS.
REQ-028 When the final read has PRDATA[0]=0: lock_err SHALL pulse, init_done SHALL clear, and the FSM SHALL enter IDLE; re-init requires enable low then high.
REQ-029 In WAIT, a 32-bit down-counter loaded with KICK_PERIOD-1 SHALL decrement per PCLK; reaching 0 or kick_req SHALL start KICK in the next cycle (SETUP op5).
REQ-030 The timer SHALL reload on entry to WAIT, so the period is measured from the end of the previous sequence.
REQ-031 kick_req while busy SHALL set a pending flag; KICK SHALL start the cycle after entering WAIT; multiple requests while busy collapse to one.
REQ-032 Timer expiry and kick_req in the same cycle SHALL produce exactly one KICK.
REQ-033 If enable falls mid-sequence, the sequence SHALL complete, then go to IDLE; init_done clears and the pending flag drops.
REQ-034 enable low in WAIT SHALL go to IDLE next cycle with no transfer.

Reset
REQ-035 On PRESETn low: state IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, busy=0, init_done=0, kick_done=0, lock_err=0, pending=0, timer=0, enable-edge detector=0.
REQ-036 Assertion mid-transfer SHALL abort immediately; after release, init SHALL start only on a fresh enable rising edge.

Structure
REQ-037 The watchdog register word addresses, unlock key and CONTROL bit positions SHALL be in the shared package cmsdk_apb_watchdog_pkg, shared with the watchdog.
REQ-038 The period counter SHALL be the sub-module cmsdk_apb_watchdog_kicker_timer (load, decrement, zero flag); the op table stays in the top level.

Verification
REQ-039 Bench SHALL connect this block to cmsdk_apb_watchdog (WDOGCLK=PCLK, WDOGCLKEN=1) plus an APB protocol checker.
REQ-040 enable rise -> 10 cycles of transfers LOCK/LOAD/CONTROL/LOCK/read; LOAD=0x0000FFFF, CONTROL=0x3, init_done=1, lock_err=0.
REQ-041 KICK_PERIOD=1000, no kick_req -> KICK starts 1000 cycles after init_done; INTCLR written; kick_done pulses each period; WDOGRES never asserts.
REQ-042 kick_req three times during INIT -> exactly one KICK immediately after init; kick_done pulses once.
REQ-043 Forced responder returning PRDATA=0 on the LOCK read -> lock_err pulse, init_done=0, FSM IDLE, no further PSEL.
REQ-044 enable low at SETUP of op6 -> ops 6-8 complete, then IDLE; PRESETn low mid-ACCESS -> PSEL=PENABLE=0 the same cycle.

Source files
------------

// File: rtl/cmsdk_apb_watchdog_pkg.sv
// Shared CMSDK APB watchdog register map, unlock key and CONTROL bit positions,
// plus the kicker FSM state and per-transfer descriptor types.
package cmsdk_apb_watchdog_pkg;

  localparam logic [9:0]  WDOG_LOAD_ADDR    = 10'h000;
  localparam logic [9:0]  WDOG_CONTROL_ADDR = 10'h002;
  localparam logic [9:0]  WDOG_INTCLR_ADDR  = 10'h003;
  localparam logic [9:0]  WDOG_LOCK_ADDR    = 10'h300;

  localparam logic [31:0] WDOG_UNLOCK_KEY   = 32'h1ACC_E551;
  localparam logic [31:0] WDOG_LOCK_VALUE   = 32'h0000_0000;
  localparam logic [31:0] WDOG_INTCLR_VALUE = 32'h0000_0001;

  localparam int WDOG_CTRL_INTEN_BIT = 0;
  localparam int WDOG_CTRL_RESEN_BIT = 1;

  // Op table indices: 0-4 are the INIT sequence, 5-8 the KICK sequence.
  localparam logic [3:0] OP_INIT_FIRST = 4'd0;
  localparam logic [3:0] OP_INIT_LAST  = 4'd4;
  localparam logic [3:0] OP_KICK_FIRST = 4'd5;
  localparam logic [3:0] OP_KICK_LAST  = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } kicker_state_e;

  typedef struct packed {
    logic [9:0]  addr;
    logic        write;
    logic [31:0] wdata;
  } apb_op_t;

endpackage

// File: rtl/cmsdk_apb_watchdog_kicker_timer.sv
// Kick period down-counter: load wins over decrement, holds at zero.
// One cycle from load to the loaded value being visible; zero flag is combinational.
module cmsdk_apb_watchdog_kicker_timer (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        dec,
  output logic        zero
);

  logic [31:0] count;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= 32'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 32'd0)) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == 32'd0);

endmodule

// File: rtl/cmsdk_apb_watchdog_kicker.sv
// APB initiator that unlocks, programs and relocks the CMSDK watchdog, then kicks it
// periodically or on request; zero-wait-state target, so every transfer is two cycles.
module cmsdk_apb_watchdog_kicker
  import cmsdk_apb_watchdog_pkg::*;
#(
  parameter logic [31:0] LOAD_VALUE  = 32'h0000_FFFF,
  parameter logic [1:0]  CTRL_VALUE  = 2'b11,
  parameter logic [31:0] KICK_PERIOD = 32'd1000
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [11:2] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        enable,
  input  logic        kick_req,
  output logic        busy,
  output logic        init_done,
  output logic        kick_done,
  output logic        lock_err
);

  function automatic apb_op_t op_entry(input logic [3:0] idx);
    apb_op_t e;
    e = '0;
    case (idx)
      4'd0, 4'd5: begin e.addr = WDOG_LOCK_ADDR;    e.write = 1'b1; e.wdata = WDOG_UNLOCK_KEY; end
      4'd1:       begin e.addr = WDOG_LOAD_ADDR;    e.write = 1'b1; e.wdata = LOAD_VALUE; end
      4'd2: begin
        e.addr  = WDOG_CONTROL_ADDR;
        e.write = 1'b1;
        e.wdata[WDOG_CTRL_INTEN_BIT] = CTRL_VALUE[0];
        e.wdata[WDOG_CTRL_RESEN_BIT] = CTRL_VALUE[1];
      end
      4'd3, 4'd7: begin e.addr = WDOG_LOCK_ADDR;    e.write = 1'b1; e.wdata = WDOG_LOCK_VALUE; end
      4'd6:       begin e.addr = WDOG_INTCLR_ADDR;  e.write = 1'b1; e.wdata = WDOG_INTCLR_VALUE; end
      4'd4, 4'd8: begin e.addr = WDOG_LOCK_ADDR;    e.write = 1'b0; end
      default:    e = '0;
    endcase
    return e;
  endfunction

  kicker_state_e state, state_nxt;
  logic [3:0]    op, op_nxt;
  logic          enable_q, armed;
  logic          pending, pending_nxt;
  logic          init_done_nxt, kick_done_nxt, lock_err_nxt;
  logic          timer_load, timer_dec, timer_zero, timer_expired;
  logic          enable_rise, in_seq, last_op;
  logic          unused_prdata;
  apb_op_t       cur;

  // A level held high across reset is not an edge: enable must be seen low first.
  assign enable_rise   = enable && !enable_q && armed;
  assign in_seq        = (state == SETUP) || (state == ACCESS);
  assign last_op       = (op == OP_INIT_LAST) || (op == OP_KICK_LAST);
  assign timer_expired = (KICK_PERIOD != 32'd0) && timer_zero;
  assign cur           = op_entry(op);
  assign unused_prdata = ^PRDATA[31:1];

  assign PSEL    = in_seq;
  assign PENABLE = (state == ACCESS);
  assign PADDR   = in_seq ? cur.addr  : 10'd0;
  assign PWRITE  = in_seq ? cur.write : 1'b0;
  assign PWDATA  = in_seq ? cur.wdata : 32'd0;
  assign busy    = in_seq;

  cmsdk_apb_watchdog_kicker_timer u_timer (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .load       (timer_load),
    .load_value (KICK_PERIOD - 32'd1),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      op        <= 4'd0;
      enable_q  <= 1'b0;
      armed     <= 1'b0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      kick_done <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      op        <= op_nxt;
      enable_q  <= enable;
      armed     <= armed || !enable;
      pending   <= pending_nxt;
      init_done <= init_done_nxt;
      kick_done <= kick_done_nxt;
      lock_err  <= lock_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    op_nxt        = op;
    pending_nxt   = pending;
    init_done_nxt = init_done;
    kick_done_nxt = 1'b0;
    lock_err_nxt  = 1'b0;
    timer_load    = 1'b0;
    timer_dec     = 1'b0;
    case (state)
      IDLE: begin
        pending_nxt   = 1'b0;
        init_done_nxt = 1'b0;
        if (enable_rise) begin
          state_nxt = SETUP;
          op_nxt    = OP_INIT_FIRST;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
        if (kick_req) pending_nxt = 1'b1;
      end
      ACCESS: begin
        if (kick_req) pending_nxt = 1'b1;
        if (!last_op) begin
          state_nxt = SETUP;
          op_nxt    = op + 4'd1;
        end else if (!PRDATA[0]) begin
          // Watchdog did not report locked: stop servicing it altogether.
          lock_err_nxt  = 1'b1;
          init_done_nxt = 1'b0;
          pending_nxt   = 1'b0;
          state_nxt     = IDLE;
        end else begin
          if (op == OP_KICK_LAST) kick_done_nxt = 1'b1;
          if (!enable) begin
            state_nxt     = IDLE;
            init_done_nxt = 1'b0;
            pending_nxt   = 1'b0;
          end else begin
            state_nxt     = WAIT;
            init_done_nxt = 1'b1;
            timer_load    = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!enable) begin
          state_nxt     = IDLE;
          init_done_nxt = 1'b0;
          pending_nxt   = 1'b0;
        end else if (pending || kick_req || timer_expired) begin
          state_nxt   = SETUP;
          op_nxt      = OP_KICK_FIRST;
          pending_nxt = 1'b0;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmsdk_apb_watchdog_kicker.sv
// Bench: kicker against a behavioural watchdog responder and APB monitor; expected
// transfer/pulse timing comes from a cycle-level schedule model of the kick rules.
module tb_cmsdk_apb_watchdog_kicker;

  localparam int          P        = 1000;
  localparam logic [9:0]  A_LOAD   = 10'h000;
  localparam logic [9:0]  A_CTRL   = 10'h002;
  localparam logic [9:0]  A_INTCLR = 10'h003;
  localparam logic [9:0]  A_LOCK   = 10'h300;
  localparam logic [31:0] KEY      = 32'h1ACCE551;

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  addr;
    logic        wr;
    logic [31:0] wd;
  } xfer_t;

  logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
  logic [11:2] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        enable, kick_req, busy, init_done, kick_done, lock_err;

  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  int    cmp_idx = 0;
  int    init_rise = -1;
  int    intclr_cnt = 0;
  xfer_t xfers[$], exp_x[$];
  int    reqs[$], kd_q[$], le_q[$], exp_kd[$];

  cmsdk_apb_watchdog_kicker #(
    .LOAD_VALUE  (32'h0000_FFFF),
    .CTRL_VALUE  (2'b11),
    .KICK_PERIOD (P)
  ) dut (
    .PCLK (PCLK), .PRESETn (PRESETn), .PSEL (PSEL), .PENABLE (PENABLE),
    .PADDR (PADDR), .PWRITE (PWRITE), .PWDATA (PWDATA), .PRDATA (PRDATA),
    .enable (enable), .kick_req (kick_req), .busy (busy),
    .init_done (init_done), .kick_done (kick_done), .lock_err (lock_err)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  // Behavioural watchdog responder: lock register gates all other writes.
  logic [31:0] wd_load, wd_ctrl;
  logic        wd_locked, force_bad;
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wd_load   <= 32'hFFFF_FFFF;
      wd_ctrl   <= 32'd0;
      wd_locked <= 1'b0;
    end else if (PSEL && PENABLE && PWRITE) begin
      if (PADDR == A_LOCK) wd_locked <= (PWDATA != KEY);
      else if (!wd_locked) begin
        if (PADDR == A_LOAD) wd_load <= PWDATA;
        if (PADDR == A_CTRL) wd_ctrl <= PWDATA;
        if (PADDR == A_INTCLR) intclr_cnt <= intclr_cnt + 1;
      end
    end
  end
  assign PRDATA = (PSEL && !PWRITE && PADDR == A_LOCK && !force_bad) ? {31'd0, wd_locked} : 32'd0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge PCLK) begin
    kick_req = 1'b0;
    foreach (reqs[i]) if (reqs[i] == cyc) kick_req = 1'b1;
  end

  // APB monitor/protocol checker plus pulse recorder.
  xfer_t set_x, acc_x;
  bit    have_setup = 0;
  always @(negedge PCLK) begin
    if (!PRESETn) have_setup = 0;
    else if (PSEL && !PENABLE) begin
      have_setup = 1;
      set_x = '{cyc: 32'(cyc), addr: PADDR, wr: PWRITE, wd: PWDATA};
    end else if (PSEL && PENABLE) begin
      acc_x = '{cyc: 32'(cyc - 1), addr: PADDR, wr: PWRITE, wd: PWDATA};
      check("apb_setup_then_access", 96'({have_setup, acc_x}), 96'({1'b1, set_x}));
      xfers.push_back(acc_x);
      have_setup = 0;
    end else check("apb_penable_without_psel", 96'(PENABLE), 96'(0));
    if (kick_done) kd_q.push_back(cyc);
    if (lock_err) le_q.push_back(cyc);
    if (init_done && init_rise < 0) init_rise = cyc;
  end

  task automatic push_op(input int c, input int idx);
    xfer_t x;
    x = '{cyc: 32'(c), addr: A_LOCK, wr: 1'b1, wd: 32'd0};
    case (idx)
      0, 5: x.wd = KEY;
      1: begin x.addr = A_LOAD; x.wd = 32'h0000_FFFF; end
      2: begin x.addr = A_CTRL; x.wd = 32'h3; end
      6: begin x.addr = A_INTCLR; x.wd = 32'h1; end
      4, 8: x.wr = 1'b0;
      default: ;
    endcase
    exp_x.push_back(x);
  endtask

  task automatic push_init(input int e);
    for (int i = 0; i < 5; i++) push_op(e + 1 + 2 * i, i);
  endtask

  task automatic push_kick(input int s);
    for (int i = 0; i < 4; i++) push_op(s + 2 * i, 5 + i);
  endtask

  task automatic cmp_xfers();
    check("xfer_count", 96'(xfers.size()), 96'(exp_x.size()));
    for (int i = cmp_idx; i < exp_x.size() && i < xfers.size(); i++)
      check($sformatf("xfer%0d", i), 96'(xfers[i]), 96'(exp_x[i]));
    cmp_idx = exp_x.size();
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge PCLK);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int  e, w, start, s, h, mode, e2, e3, e4;
    bit  pend, outstanding, coinc_done;
    PRESETn = 1'b1; enable = 1'b0; force_bad = 1'b0;
    #1 PRESETn = 1'b0;
    #2;
    check("rst_psel", 96'(PSEL), 96'(0));
    check("rst_penable", 96'(PENABLE), 96'(0));
    check("rst_paddr", 96'(PADDR), 96'(0));
    check("rst_pwrite", 96'(PWRITE), 96'(0));
    check("rst_pwdata", 96'(PWDATA), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_init_done", 96'(init_done), 96'(0));
    check("rst_kick_done", 96'(kick_done), 96'(0));
    check("rst_lock_err", 96'(lock_err), 96'(0));
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    // Init with three requests inside the init window, then randomized kicks.
    e = cyc;
    repeat (3) reqs.push_back(e + 1 + int'($urandom_range(0, 9)));
    push_init(e);
    w = e + 11; pend = 1'b1; coinc_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      outstanding = 1'b0;
      foreach (reqs[i]) if (reqs[i] >= w) outstanding = 1'b1;
      if (k >= 6 && !pend && !outstanding) break;
      mode = (k >= 6) ? 0 : int'($urandom_range(0, 3));
      if (k >= 1 && !pend && !coinc_done) begin mode = 2; coinc_done = 1'b1; end
      if (mode == 1) reqs.push_back(w + int'($urandom_range(0, P + 10)));
      if (mode == 2) reqs.push_back(w + P - 1);
      if (pend) start = w + 1;
      else begin
        start = w + P;
        foreach (reqs[i]) if (reqs[i] >= w && reqs[i] + 1 < start) start = reqs[i] + 1;
      end
      if (mode == 3) repeat (2) reqs.push_back(start + int'($urandom_range(0, 7)));
      pend = 1'b0;
      foreach (reqs[i]) if (reqs[i] >= start && reqs[i] <= start + 7) pend = 1'b1;
      push_kick(start);
      exp_kd.push_back(start + 8);
      w = start + 8;
    end
    h = exp_kd[exp_kd.size() - 1] + 20;

    enable = 1'b1;
    wait_cyc(e + 5);
    check("busy_mid_init", 96'(busy), 96'(1));
    wait_cyc(e + 11);
    check("init_done_set", 96'(init_done), 96'(1));
    check("busy_after_init", 96'(busy), 96'(0));
    check("wdog_load", 96'(wd_load), 96'(32'h0000_FFFF));
    check("wdog_ctrl", 96'(wd_ctrl), 96'(32'h3));
    check("wdog_locked", 96'(wd_locked), 96'(1));
    wait_cyc(h);
    cmp_xfers();
    check("init_rise_cycle", 96'(init_rise), 96'(e + 11));
    check("kick_done_count", 96'(kd_q.size()), 96'(exp_kd.size()));
    for (int i = 0; i < exp_kd.size() && i < kd_q.size(); i++)
      check($sformatf("kick_done%0d", i), 96'(kd_q[i]), 96'(exp_kd[i]));
    check("intclr_count", 96'(intclr_cnt), 96'(exp_kd.size()));
    check("no_lock_err", 96'(le_q.size()), 96'(0));

    // Enable drops during the INTCLR setup: the kick finishes, then idle.
    reqs.push_back(h + 1);
    s = h + 2;
    push_kick(s);
    wait_cyc(s + 2);
    enable = 1'b0;
    wait_cyc(s + 8);
    check("stop_init_done", 96'(init_done), 96'(0));
    check("stop_busy", 96'(busy), 96'(0));
    wait_cyc(s + 60);
    cmp_xfers();

    // Lock readback fails.
    e2 = cyc;
    force_bad = 1'b1;
    enable = 1'b1;
    push_init(e2);
    wait_cyc(e2 + 11);
    check("lockerr_pulse", 96'(lock_err), 96'(1));
    check("lockerr_init_done", 96'(init_done), 96'(0));
    check("lockerr_busy", 96'(busy), 96'(0));
    wait_cyc(e2 + 60);
    cmp_xfers();
    check("lockerr_count", 96'(le_q.size()), 96'(1));
    if (le_q.size() > 0) check("lockerr_cycle", 96'(le_q[0]), 96'(e2 + 11));

    // Reset in the ACCESS phase of the first init transfer.
    force_bad = 1'b0;
    enable = 1'b0;
    @(negedge PCLK);
    enable = 1'b1;
    e3 = cyc;
    push_op(e3 + 1, 0);
    wait_cyc(e3 + 2);
    check("pre_reset_access", 96'(PENABLE), 96'(1));
    #1 PRESETn = 1'b0;
    #1;
    check("rst_abort_psel", 96'(PSEL), 96'(0));
    check("rst_abort_penable", 96'(PENABLE), 96'(0));
    check("rst_abort_busy", 96'(busy), 96'(0));
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (30) @(negedge PCLK);
    cmp_xfers();
    check("no_init_without_edge", 96'(init_done), 96'(0));
    enable = 1'b0;
    @(negedge PCLK);
    enable = 1'b1;
    e4 = cyc;
    push_init(e4);
    wait_cyc(e4 + 11);
    check("reinit_done", 96'(init_done), 96'(1));
    check("reinit_load", 96'(wd_load), 96'(32'h0000_FFFF));
    wait_cyc(e4 + 15);
    cmp_xfers();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
